// File: rtl/sevenseg_pkg.sv
// Shared types, glyph constants and sizing helpers for the seven-segment scanner.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  // Active-low segment patterns, bit6=g down to bit0=a.
  localparam seg_t SEG_0   = 7'b1000000;
  localparam seg_t SEG_1   = 7'b1111001;
  localparam seg_t SEG_2   = 7'b0100100;
  localparam seg_t SEG_3   = 7'b0110000;
  localparam seg_t SEG_4   = 7'b0011001;
  localparam seg_t SEG_5   = 7'b0010010;
  localparam seg_t SEG_6   = 7'b0000010;
  localparam seg_t SEG_7   = 7'b1111000;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0010000;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b0000011;
  localparam seg_t SEG_C   = 7'b1000110;
  localparam seg_t SEG_D   = 7'b0100001;
  localparam seg_t SEG_E   = 7'b0000110;
  localparam seg_t SEG_F   = 7'b0001110;
  localparam seg_t SEG_ERR = 7'b0000110;
  localparam seg_t SEG_OFF = 7'b1111111;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg_decode
  import sevenseg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = (HEX_MODE != 0) ? SEG_A : SEG_ERR;
      4'hB: seg = (HEX_MODE != 0) ? SEG_B : SEG_ERR;
      4'hC: seg = (HEX_MODE != 0) ? SEG_C : SEG_ERR;
      4'hD: seg = (HEX_MODE != 0) ? SEG_D : SEG_ERR;
      4'hE: seg = (HEX_MODE != 0) ? SEG_E : SEG_ERR;
      4'hF: seg = (HEX_MODE != 0) ? SEG_F : SEG_ERR;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode display driver with double-buffered value,
// leading-zero blanking and per-slot anode ghost blanking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 2,
  parameter int HEX_MODE = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   blank_lz,
  output logic [6:0]             segs,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an_n,
  output logic                   frame_done
);

  localparam int PW = cnt_width(SCAN_DIV);
  localparam int DW = cnt_width(NDIGITS);
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(NDIGITS - 1);

  logic [PW-1:0]          p_reg;
  logic [DW-1:0]          d_reg;
  logic [4*NDIGITS-1:0]   pend_val_reg, disp_val_reg;
  logic [NDIGITS-1:0]     pend_dp_reg, disp_dp_reg;
  logic                   pend_lz_reg, disp_lz_reg, pend_flag_reg;
  seg_t                   segs_reg;
  logic                   dp_n_reg, frame_done_reg;
  logic [NDIGITS-1:0]     an_n_reg;

  logic                   slot_end, frame_end, lit;
  logic [3:0]             nib [NDIGITS];
  logic [NDIGITS-1:0]     upper_zero;
  logic [3:0]             nib_sel;
  seg_t                   dec_seg, segs_next;
  logic [NDIGITS-1:0]     an_next;
  logic                   blank_sel;

  assign slot_end  = enable && (p_reg == P_LAST);
  assign frame_end = slot_end && (d_reg == D_LAST);

  // upper_zero[i]: nibbles i..NDIGITS-1 of the displayed value are all zero.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign nib[gi]        = disp_val_reg[4*gi +: 4];
      assign upper_zero[gi] = (disp_val_reg[4*NDIGITS-1:4*gi] == '0);
    end
    if (BLANK == 0) begin : g_noblank
      assign lit = 1'b1;
    end else begin : g_blank
      assign lit = (p_reg >= PW'(BLANK));
    end
  endgenerate

  assign nib_sel   = nib[d_reg];
  assign blank_sel = disp_lz_reg && (d_reg != '0) && upper_zero[d_reg];

  seg_decode #(.HEX_MODE(HEX_MODE)) u_decode (
    .nib (nib_sel),
    .seg (dec_seg)
  );

  always_comb begin
    segs_next = SEG_OFF;
    an_next   = '1;
    if (enable) begin
      segs_next = blank_sel ? SEG_OFF : dec_seg;
      if (lit) an_next[d_reg] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_reg <= '0;
      d_reg <= '0;
    end else if (slot_end) begin
      p_reg <= '0;
      d_reg <= (d_reg == D_LAST) ? '0 : d_reg + 1'b1;
    end else if (enable) begin
      p_reg <= p_reg + 1'b1;
    end
  end

  // A load coinciding with the frame boundary goes straight to the display.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_val_reg  <= '0;
      pend_dp_reg   <= '0;
      pend_lz_reg   <= 1'b0;
      pend_flag_reg <= 1'b0;
      disp_val_reg  <= '0;
      disp_dp_reg   <= '0;
      disp_lz_reg   <= 1'b0;
    end else if (frame_end) begin
      pend_flag_reg <= 1'b0;
      if (load) begin
        disp_val_reg <= value;
        disp_dp_reg  <= dp_in;
        disp_lz_reg  <= blank_lz;
      end else if (pend_flag_reg) begin
        disp_val_reg <= pend_val_reg;
        disp_dp_reg  <= pend_dp_reg;
        disp_lz_reg  <= pend_lz_reg;
      end
    end else if (load) begin
      pend_val_reg  <= value;
      pend_dp_reg   <= dp_in;
      pend_lz_reg   <= blank_lz;
      pend_flag_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      segs_reg       <= SEG_OFF;
      dp_n_reg       <= 1'b1;
      an_n_reg       <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      segs_reg       <= segs_next;
      dp_n_reg       <= enable ? ~disp_dp_reg[d_reg] : 1'b1;
      an_n_reg       <= an_next;
      frame_done_reg <= frame_end;
    end
  end

  assign segs       = segs_reg;
  assign dp_n       = dp_n_reg;
  assign an_n       = an_n_reg;
  assign frame_done = frame_done_reg;

endmodule
